// File: rtl/mem_io_bridge_if.sv
// Bundled CPU, main-memory and I/O-channel signals of mem_io_bridge.
// slave is the bridge's view; master is the CPU/target side.
interface mem_io_bridge_if #(
  parameter int unsigned NCH = 4
) ();
  logic [31:0]      m_a;
  logic [31:0]      m_d_w;
  logic             m_access;
  logic             m_write;
  logic [31:0]      m_d_r;
  logic             m_ready;
  logic             m_err;

  logic [31:0]      mem_a;
  logic [31:0]      mem_d_w;
  logic             mem_access;
  logic             mem_write;
  logic [31:0]      mem_d_r;
  logic             mem_ready;

  logic [31:0]      io_a;
  logic [31:0]      io_d_w;
  logic [NCH-1:0]   io_access;
  logic             io_write;
  logic [32*NCH-1:0] io_d_r;
  logic [NCH-1:0]   io_ready;

  modport slave (
    input  m_a, m_d_w, m_access, m_write, mem_d_r, mem_ready, io_d_r, io_ready,
    output m_d_r, m_ready, m_err, mem_a, mem_d_w, mem_access, mem_write,
           io_a, io_d_w, io_access, io_write
  );

  modport master (
    output m_a, m_d_w, m_access, m_write, mem_d_r, mem_ready, io_d_r, io_ready,
    input  m_d_r, m_ready, m_err, mem_a, mem_d_w, mem_access, mem_write,
           io_a, io_d_w, io_access, io_write
  );
endinterface

// File: rtl/mem_io_bridge.sv
// Registered bridge from the CPU memory port to main memory or one of NCH I/O channels.
// Define BRIDGE_TIMEOUT_EN to complete unresponsive accesses with an error after TIMEOUT cycles.
module mem_io_bridge #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned CHW     = 2,
  parameter logic [3:0]  IO_SEL  = 4'hA,
  parameter int unsigned CH_LSB  = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic      clk,
  input  logic      clr,
  mem_io_bridge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q;
  logic            is_io_q;
  logic            write_q;
  logic [31:0]     m_d_r_q;
  logic            m_ready_q;
  logic            m_err_q;
  logic [31:0]     mem_a_q;
  logic [31:0]     mem_d_w_q;
  logic            mem_access_q;
  logic            mem_write_q;
  logic [31:0]     io_a_q;
  logic [31:0]     io_d_w_q;
  logic [NCH-1:0]  io_access_q;
  logic            io_write_q;
`ifdef BRIDGE_TIMEOUT_EN
  logic [15:0]     cnt_q;
`endif

  logic            dec_io;
  logic [CHW-1:0]  dec_ch;
  logic            dec_ok;
  logic            sel_ready;
  logic [31:0]     sel_data;

  assign dec_io = (bus.m_a[31:28] == IO_SEL);
  assign dec_ch = bus.m_a[CH_LSB +: CHW];
  assign dec_ok = (32'(dec_ch) < NCH);

  // Ready/data of the single target being served; the one-hot strobe masks other channels.
  always_comb begin
    sel_ready = bus.mem_ready;
    sel_data  = bus.mem_d_r;
    if (is_io_q) begin
      sel_ready = |(bus.io_ready & io_access_q);
      sel_data  = '0;
      for (int c = 0; c < int'(NCH); c++) begin
        if (io_access_q[c]) sel_data = sel_data | bus.io_d_r[32*c +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      is_io_q      <= 1'b0;
      write_q      <= 1'b0;
      m_d_r_q      <= '0;
      m_ready_q    <= 1'b0;
      m_err_q      <= 1'b0;
      mem_a_q      <= '0;
      mem_d_w_q    <= '0;
      mem_access_q <= 1'b0;
      mem_write_q  <= 1'b0;
      io_a_q       <= '0;
      io_d_w_q     <= '0;
      io_access_q  <= '0;
      io_write_q   <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.m_access) begin
            is_io_q <= dec_io;
            write_q <= bus.m_write;
            if (dec_io && !dec_ok) begin
              // Nonexistent channel: complete immediately, no target touched.
              m_ready_q <= 1'b1;
              m_err_q   <= 1'b1;
              m_d_r_q   <= '0;
              state_q   <= DONE;
            end else begin
              mem_a_q      <= bus.m_a;
              mem_d_w_q    <= bus.m_d_w;
              io_a_q       <= bus.m_a;
              io_d_w_q     <= bus.m_d_w;
              mem_access_q <= !dec_io;
              mem_write_q  <= !dec_io && bus.m_write;
              io_access_q  <= dec_io ? (NCH'(1) << dec_ch) : '0;
              io_write_q   <= dec_io && bus.m_write;
`ifdef BRIDGE_TIMEOUT_EN
              cnt_q        <= '0;
`endif
              state_q      <= BUSY;
            end
          end
        end

        BUSY: begin
          if (sel_ready) begin
            mem_access_q <= 1'b0;
            mem_write_q  <= 1'b0;
            io_access_q  <= '0;
            io_write_q   <= 1'b0;
            m_ready_q    <= 1'b1;
            m_err_q      <= 1'b0;
            m_d_r_q      <= write_q ? 32'd0 : sel_data;
            state_q      <= DONE;
          end
`ifdef BRIDGE_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q + 16'd1 == 16'(TIMEOUT)) begin
              mem_access_q <= 1'b0;
              mem_write_q  <= 1'b0;
              io_access_q  <= '0;
              io_write_q   <= 1'b0;
              m_ready_q    <= 1'b1;
              m_err_q      <= 1'b1;
              m_d_r_q      <= '0;
              state_q      <= DONE;
            end
          end
`endif
        end

        DONE: begin
          m_ready_q <= 1'b0;
          state_q   <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m_d_r      = m_d_r_q;
  assign bus.m_ready    = m_ready_q;
  assign bus.m_err      = m_err_q;
  assign bus.mem_a      = mem_a_q;
  assign bus.mem_d_w    = mem_d_w_q;
  assign bus.mem_access = mem_access_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.io_a       = io_a_q;
  assign bus.io_d_w     = io_d_w_q;
  assign bus.io_access  = io_access_q;
  assign bus.io_write   = io_write_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed self-checking bench for mem_io_bridge (3 channels, TIMEOUT=8).
// Timeout cases run only when BRIDGE_TIMEOUT_EN is defined.
module tb_mem_io_bridge;
  localparam int unsigned NCH = 3;
  localparam int unsigned TO  = 8;
  localparam logic [31:0] MEM_JUNK = 32'hEEEE_EEEE;
  localparam logic [95:0] IO_JUNK  = {32'hD2D2_D2D2, 32'hD1D1_D1D1, 32'hD0D0_D0D0};

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  mem_io_bridge_if #(.NCH(NCH)) bus ();

  mem_io_bridge #(
    .NCH(NCH), .CHW(2), .IO_SEL(4'hA), .CH_LSB(12), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus.slave)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_targets();
    bus.mem_ready = 1'b0;
    bus.io_ready  = '0;
    bus.mem_d_r   = MEM_JUNK;
    bus.io_d_r    = IO_JUNK;
  endtask

  function automatic logic [31:0] strobes();
    return {28'd0, bus.io_access, bus.mem_access};
  endfunction

  // One CPU transaction; target answers on strobe cycle ready_at (0 = never),
  // and unrelated targets pulse ready on the first strobe cycle as a distraction.
  task automatic xact(input string tag, input logic [31:0] a, input logic [31:0] wd,
                      input logic w, input int ready_at, input logic [31:0] rdata,
                      input bit hold, output int lat, output int strb,
                      output logic [31:0] rd, output logic err, output logic [2:0] acc,
                      output logic wr, output logic [31:0] a_seen, output logic [31:0] dw_seen);
    bit tio;
    int ch;
    bit done;
    tio = (a[31:28] == 4'hA);
    ch  = int'(a[13:12]);
    lat = 0; strb = 0; acc = '0; wr = 1'b0; a_seen = '0; dw_seen = '0;
    rd = '0; err = 1'b0; done = 1'b0;
    @(negedge clk);
    bus.m_a = a; bus.m_d_w = wd; bus.m_write = w; bus.m_access = 1'b1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      idle_targets();
      if (bus.m_ready) begin
        done = 1'b1;
        rd   = bus.m_d_r;
        err  = bus.m_err;
        chk({tag, "_strobe_off"}, strobes(), 32'd0);
        if (!hold) bus.m_access = 1'b0;
      end else if (bus.mem_access || (|bus.io_access)) begin
        strb++;
        acc = acc | bus.io_access;
        wr  = wr | bus.mem_write | bus.io_write;
        if (bus.mem_access) begin a_seen = bus.mem_a; dw_seen = bus.mem_d_w; end
        else begin a_seen = bus.io_a; dw_seen = bus.io_d_w; end
        if (strb == ready_at) begin
          if (tio) begin bus.io_ready[ch] = 1'b1; bus.io_d_r[32*ch +: 32] = rdata; end
          else begin bus.mem_ready = 1'b1; bus.mem_d_r = rdata; end
        end else if (strb == 1) begin
          if (tio) begin bus.mem_ready = 1'b1; bus.io_ready = ~(3'b001 << ch); end
          else bus.io_ready = '1;
        end
      end
    end
    chk({tag, "_completed"}, 32'(done), 32'd1);
  endtask

  task automatic pulse_end(input string tag);
    @(posedge clk); #1;
    chk({tag, "_ready_pulse"}, 32'(bus.m_ready), 32'd0);
  endtask

  int lat, strb;
  logic [31:0] rd, a_seen, dw_seen;
  logic err, wr;
  logic [2:0] acc;
  logic seen_ready;

  initial begin
    clr = 1'b1;
    bus.m_a = '0; bus.m_d_w = '0; bus.m_access = 1'b0; bus.m_write = 1'b0;
    idle_targets();
    #12;
    chk("rst_m_ready", 32'(bus.m_ready), 32'd0);
    chk("rst_m_err", 32'(bus.m_err), 32'd0);
    chk("rst_m_d_r", bus.m_d_r, 32'd0);
    chk("rst_strobes", strobes(), 32'd0);
    chk("rst_writes", {30'd0, bus.mem_write, bus.io_write}, 32'd0);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_io_d_w", bus.io_d_w, 32'd0);
    @(negedge clk); clr = 1'b0;

    // memory read, ready on first BUSY cycle
    xact("mrd", 32'h0000_1000, 32'h0, 1'b0, 1, 32'h1234_5678, 1'b0,
         lat, strb, rd, err, acc, wr, a_seen, dw_seen);
    chk("mrd_lat", 32'(lat), 32'd2);
    chk("mrd_data", rd, 32'h1234_5678);
    chk("mrd_err", 32'(err), 32'd0);
    chk("mrd_io_acc", 32'(acc), 32'd0);
    chk("mrd_addr", a_seen, 32'h0000_1000);
    pulse_end("mrd");

    // I/O write to channel 2, ready on third strobe cycle
    xact("iowr", 32'hA000_2004, 32'hCAFE_F00D, 1'b1, 3, 32'h7777_7777, 1'b0,
         lat, strb, rd, err, acc, wr, a_seen, dw_seen);
    chk("iowr_lat", 32'(lat), 32'd4);
    chk("iowr_strb", 32'(strb), 32'd3);
    chk("iowr_acc", 32'(acc), 32'b100);
    chk("iowr_write", 32'(wr), 32'd1);
    chk("iowr_dw", dw_seen, 32'hCAFE_F00D);
    chk("iowr_addr", a_seen, 32'hA000_2004);
    chk("iowr_data", rd, 32'd0);
    chk("iowr_err", 32'(err), 32'd0);
    pulse_end("iowr");

    // I/O read from channel 0
    xact("iord", 32'hA000_0010, 32'h0, 1'b0, 2, 32'h0BAD_BEEF, 1'b0,
         lat, strb, rd, err, acc, wr, a_seen, dw_seen);
    chk("iord_lat", 32'(lat), 32'd3);
    chk("iord_data", rd, 32'h0BAD_BEEF);
    chk("iord_acc", 32'(acc), 32'b001);
    chk("iord_write", 32'(wr), 32'd0);
    pulse_end("iord");
    repeat (2) @(posedge clk);
    #1 chk("hold_m_d_r", bus.m_d_r, 32'h0BAD_BEEF);

    // channel 3 does not exist with three channels
    xact("decerr", 32'hA000_3000, 32'h0, 1'b0, 1, 32'h5A5A_5A5A, 1'b0,
         lat, strb, rd, err, acc, wr, a_seen, dw_seen);
    chk("decerr_lat", 32'(lat), 32'd1);
    chk("decerr_err", 32'(err), 32'd1);
    chk("decerr_data", rd, 32'd0);
    chk("decerr_strb", 32'(strb), 32'd0);
    pulse_end("decerr");

    // memory write
    xact("mwr", 32'h0000_0040, 32'h5555_AAAA, 1'b1, 1, 32'h9999_9999, 1'b0,
         lat, strb, rd, err, acc, wr, a_seen, dw_seen);
    chk("mwr_lat", 32'(lat), 32'd2);
    chk("mwr_data", rd, 32'd0);
    chk("mwr_write", 32'(wr), 32'd1);
    chk("mwr_dw", dw_seen, 32'h5555_AAAA);
    chk("mwr_err", 32'(err), 32'd0);
    pulse_end("mwr");

    // back-to-back with m_access held: read then I/O write to channel 1
    xact("b2b1", 32'h0000_0100, 32'h0, 1'b0, 1, 32'h0000_00A1, 1'b1,
         lat, strb, rd, err, acc, wr, a_seen, dw_seen);
    chk("b2b1_lat", 32'(lat), 32'd2);
    chk("b2b1_data", rd, 32'h0000_00A1);
    xact("b2b2", 32'hA000_1008, 32'h1357_9BDF, 1'b1, 1, 32'h0, 1'b0,
         lat, strb, rd, err, acc, wr, a_seen, dw_seen);
    chk("b2b2_lat", 32'(lat), 32'd3);
    chk("b2b2_acc", 32'(acc), 32'b010);
    chk("b2b2_data", rd, 32'd0);
    pulse_end("b2b2");

`ifdef BRIDGE_TIMEOUT_EN
    xact("tmo", 32'h0000_3000, 32'h0, 1'b0, 0, 32'h1111_1111, 1'b0,
         lat, strb, rd, err, acc, wr, a_seen, dw_seen);
    chk("tmo_lat", 32'(lat), 32'd9);
    chk("tmo_strb", 32'(strb), 32'd8);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_data", rd, 32'd0);
    pulse_end("tmo");
    xact("tmo_edge", 32'h0000_3004, 32'h0, 1'b0, 8, 32'h2222_3333, 1'b0,
         lat, strb, rd, err, acc, wr, a_seen, dw_seen);
    chk("tmo_edge_lat", 32'(lat), 32'd9);
    chk("tmo_edge_err", 32'(err), 32'd0);
    chk("tmo_edge_data", rd, 32'h2222_3333);
    pulse_end("tmo_edge");
`else
    xact("long", 32'h0000_3000, 32'h0, 1'b0, 12, 32'h4444_5555, 1'b0,
         lat, strb, rd, err, acc, wr, a_seen, dw_seen);
    chk("long_lat", 32'(lat), 32'd13);
    chk("long_strb", 32'(strb), 32'd12);
    chk("long_err", 32'(err), 32'd0);
    chk("long_data", rd, 32'h4444_5555);
    pulse_end("long");
`endif

    // reset in the middle of a memory access
    @(negedge clk);
    bus.m_a = 32'h0000_2000; bus.m_write = 1'b0; bus.m_access = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("midrst_busy", 32'(bus.mem_access), 32'd1);
    #2 clr = 1'b1;
    #1;
    chk("midrst_strobes", strobes(), 32'd0);
    chk("midrst_ready", 32'(bus.m_ready), 32'd0);
    bus.m_access = 1'b0;
    @(negedge clk); clr = 1'b0;
    seen_ready = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen_ready = seen_ready | bus.m_ready;
    end
    chk("midrst_no_ready", 32'(seen_ready), 32'd0);

    xact("postrst", 32'hA000_1000, 32'h0, 1'b0, 2, 32'hFEED_0001, 1'b0,
         lat, strb, rd, err, acc, wr, a_seen, dw_seen);
    chk("postrst_lat", 32'(lat), 32'd3);
    chk("postrst_data", rd, 32'hFEED_0001);
    chk("postrst_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
